edge_sum_trigger: RTL and testbench
===================================

# edge_sum_trigger

Single-clock, parametrised edge-detection trigger for the capture path. It decimates offset-binary ADC samples by summation and forms a step metric from the decimated stream. The metric is the sum of the newest W decimated values minus the sum of the W values before them. A one-cycle trigger pulse is raised when the metric crosses a programmable threshold in the selected polarity. The block replaces the separate downsample + moving-sum pair: everything runs on `ap_clk` with valid strobes, with no derived or gated clock, and it adds a differential window, threshold compare, re-arm and holdoff.

## Interface
Parameters:
- `DATA_W`, 10 — ADC sample width, offset binary (midscale = 2^(DATA_W-1)).
- `DS_CNT_W`, 8 — width of the decimation count.
- `WIN_MAX`, 32 — maximum window depth; must be a power of two.
- Derived (localparams, not overridable):
  - `DS_W = DATA_W + DS_CNT_W`
  - `WS_W = DS_W + log2(WIN_MAX)`
  - `M_W = WS_W + 1`

Ports:
- `ap_clk` in 1 — the only clock. All logic is on its rising edge.
- `ap_rst` in 1 — synchronous, active-high reset.
- `enable` in 1 — run. Its 0→1 edge latches the configuration and restarts the pipeline. While low, the block is held in IDLE.
- `datain` in DATA_W — raw ADC sample.
- `datain_vld` in 1 — `datain` is valid this cycle.
- `abs_mode` in 1 — use |sample − midscale| instead of the signed offset value.
- `downsample_num` in DS_CNT_W — samples summed per decimated value. 0 is treated as 1.
- `window_width` in log2(WIN_MAX)+1 — W. 0 is treated as 1; values above WIN_MAX are clamped to WIN_MAX.
- `threshold` in M_W-1 — unsigned threshold magnitude.
- `edge_mode` in 2 — 01 rising, 10 falling, 11 both, 00 never trigger.
- `holdoff` in 16 — number of decimated samples after a trigger during which triggering is suppressed.
- `dsout` out DS_W — signed decimated sum.
- `dsout_vld` out 1 — `dsout` valid strobe.
- `metric` out M_W — signed value sumA − sumB.
- `metric_vld` out 1 — `metric` valid strobe.
- `trig` out 1 — one-cycle trigger pulse.
- `busy` out 1 — high in FILL, RUN or HOLDOFF.

## Operation
- Sample conditioning: s = `datain` − 2^(DATA_W-1), sign-extended to DS_W. In `abs_mode`, s = |s|, zero-extended.
- Decimator:
  - The accumulator and a sample counter advance only on `datain_vld`.
  - On the N-th valid sample: `dsout` = accumulator + s, the accumulator reloads to 0, and `dsout_vld` pulses.
  - `datain_vld` gaps stretch the decimation period but never lose data.
- Window:
  - A circular buffer of 2·WIN_MAX entries × DS_W holds the decimated values.
  - On each decimated value v: write v at `wr`, old1 = buf[wr−W], old2 = buf[wr−2W].
  - Update: sumA += v − old1; sumB += old1 − old2.
  - All indices wrap modulo 2·WIN_MAX.
  - Buffer entries and both sums are cleared on restart, so FILL reads zeros.
- State machine:
  - IDLE: outputs are quiet. Leaves on the rising edge of `enable`: latch N, W, `abs_mode`, `threshold`, `edge_mode`, `holdoff`; clear the accumulator, counter, sums, `wr` and the fill count; go to FILL.
  - FILL: count decimated values. On the 2W-th value go to RUN; that value's metric is the first with `metric_vld`.
  - RUN: evaluate cond = (rise && metric ≥ thr) || (fall && metric ≤ −thr). If cond and `armed`: pulse `trig`, clear `armed`, go to HOLDOFF (if `holdoff` = 0, stay in RUN). `armed` is set whenever a valid metric has cond false.
  - HOLDOFF: the metric keeps updating. Count `holdoff` decimated values, then return to RUN. No trigger fires during HOLDOFF; `armed` still tracks cond.
  - In any state, `enable` low → IDLE next cycle.
- Configuration changes while enabled are ignored until the next restart.
- Arithmetic: all sums are two's complement at their full derived widths. By construction no overflow is possible. `threshold` is compared after zero-extension to M_W.

## Timing
- Reset values: all outputs 0, state IDLE, `armed` = 1. `ap_rst` mid-operation behaves exactly like power-up reset. `enable` must toggle again before a new run.
- `dsout`/`dsout_vld`: registered, 1 cycle after the N-th valid `datain`.
- `metric`/`metric_vld`: registered, 1 cycle after `dsout_vld`.
- `trig`: asserted in the same cycle as the `metric_vld` that satisfies the trigger. Total latency is 2 cycles from the completing input sample.
- `enable` falling in the same cycle as `datain_vld`: that sample is discarded.
- Back-to-back `datain_vld` with N = 1: one `dsout_vld` per cycle, and the pipeline sustains full rate.

## Test plan
- Step response: N=2, W=3, thr=500, mode=01. Input 512 ×40 then 612 → first nonzero `dsout`=200; metrics 200, 400, 600; `trig` on the 600 metric, exactly once.
- Falling step: same config with mode=10, input 612 → 512 → metric −600, `trig` once. With mode=01 the same stimulus gives no `trig`.
- Holdoff and re-arm: square wave toggling every 6 decimated values, holdoff=20, mode=11 → the second edge is suppressed; the next edge triggers only after cond has gone false once.
- Fill and clamp: W=0 → W=1, first `metric_vld` after 2 decimated values. W=40 with WIN_MAX=32 → first valid after 64.
- Gaps and absolute mode: random `datain_vld` gaps with `abs_mode`=1 and input alternating 412/612 → `dsout` = 100·N, metric 0, no trigger.
- Reset mid-run: assert `ap_rst` for 1 cycle during HOLDOFF → all outputs 0 next cycle, `busy`=0, no `trig` until `enable` is re-toggled.

Source files
------------

// File: rtl/edge_sum_trigger.sv
// edge_sum_trigger
//   Decimates offset-binary ADC samples by summation, forms a differential
//   step metric (sum of newest W decimated values minus the W before them)
//   and pulses trig when the metric crosses a threshold in the chosen polarity.
// Ports:
//   ap_clk, ap_rst        single clock, synchronous active-high reset
//   enable                0->1 latches configuration and restarts; low = IDLE
//   datain, datain_vld    raw ADC sample and its strobe
//   abs_mode, downsample_num, window_width, threshold, edge_mode, holdoff
//                         run configuration, sampled only on restart
//   dsout, dsout_vld      signed decimated sum
//   metric, metric_vld    signed sumA - sumB
//   trig                  one-cycle trigger pulse, aligned with metric_vld
//   busy                  high in FILL, RUN or HOLDOFF
module edge_sum_trigger #(
  parameter int DATA_W   = 10,
  parameter int DS_CNT_W = 8,
  parameter int WIN_MAX  = 32
) (
  input  logic                                           ap_clk,
  input  logic                                           ap_rst,
  input  logic                                           enable,
  input  logic [DATA_W-1:0]                              datain,
  input  logic                                           datain_vld,
  input  logic                                           abs_mode,
  input  logic [DS_CNT_W-1:0]                            downsample_num,
  input  logic [$clog2(WIN_MAX):0]                       window_width,
  input  logic [DATA_W+DS_CNT_W+$clog2(WIN_MAX)-1:0]     threshold,
  input  logic [1:0]                                     edge_mode,
  input  logic [15:0]                                    holdoff,
  output logic [DATA_W+DS_CNT_W-1:0]                     dsout,
  output logic                                           dsout_vld,
  output logic [DATA_W+DS_CNT_W+$clog2(WIN_MAX):0]       metric,
  output logic                                           metric_vld,
  output logic                                           trig,
  output logic                                           busy
);
  localparam int LOG_WIN = $clog2(WIN_MAX);
  localparam int DS_W    = DATA_W + DS_CNT_W;
  localparam int WS_W    = DS_W + LOG_WIN;
  localparam int M_W     = WS_W + 1;
  localparam int WIN_W   = LOG_WIN + 1;
  localparam int BUF_D   = 2 * WIN_MAX;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_HOLD} state_t;

  state_t                  r_state, w_state_n;
  logic                    r_en_d;
  logic [DS_CNT_W-1:0]     r_n_m1, r_cnt, w_n_m1;
  logic [WIN_W-1:0]        r_w, w_w_lat;
  logic                    r_abs;
  logic [M_W-2:0]          r_thr;
  logic [1:0]              r_mode;
  logic [15:0]             r_holdoff, r_ho_cnt, w_ho_n;
  logic                    r_armed, w_armed_n;
  logic [WIN_W:0]          r_fill_cnt, w_fill_n, w_w2;
  logic signed [DS_W-1:0]  r_acc, r_dsout;
  logic                    r_dsout_vld;
  logic signed [DS_W-1:0]  r_buf [BUF_D];
  logic [BUF_D-1:0]        r_bvld;
  logic [WIN_W-1:0]        r_wr, w_idx1, w_idx2;
  logic signed [WS_W-1:0]  r_sum_a, r_sum_b;
  logic signed [M_W-1:0]   r_metric;
  logic                    r_metric_vld, r_trig;

  logic                    w_restart, w_eval, w_mvld_n, w_trig_n;

  // Sample conditioning: flipping the MSB subtracts midscale from offset binary.
  logic signed [DATA_W-1:0] w_s_off;
  logic signed [DS_W-1:0]   w_s_ext, w_s, w_acc_sum;
  logic                     w_accept, w_ds_last;

  assign w_s_off   = {~datain[DATA_W-1], datain[DATA_W-2:0]};
  assign w_s_ext   = {{DS_CNT_W{w_s_off[DATA_W-1]}}, w_s_off};
  assign w_s       = (r_abs && w_s_ext[DS_W-1]) ? -w_s_ext : w_s_ext;
  assign w_accept  = enable && datain_vld && (r_state != ST_IDLE);
  assign w_ds_last = (r_cnt == r_n_m1);
  assign w_acc_sum = r_acc + w_s;

  // Window arithmetic
  logic                    w_win_evt;
  logic signed [DS_W-1:0]  w_old1, w_old2;
  logic signed [WS_W-1:0]  w_v_x, w_o1_x, w_o2_x, w_sum_a_n, w_sum_b_n;
  logic signed [M_W-1:0]   w_metric_n, w_thr;
  logic                    w_cond;

  assign w_win_evt  = enable && r_dsout_vld && (r_state != ST_IDLE);
  assign w_w2       = {r_w, 1'b0};
  assign w_idx1     = r_wr - r_w;
  assign w_idx2     = r_wr - w_w2[WIN_W-1:0];
  // Entries not written since restart read as zero via the valid mask,
  // equivalent to clearing the whole buffer on restart.
  assign w_old1     = r_bvld[w_idx1] ? r_buf[w_idx1] : '0;
  assign w_old2     = r_bvld[w_idx2] ? r_buf[w_idx2] : '0;
  assign w_v_x      = {{LOG_WIN{r_dsout[DS_W-1]}}, r_dsout};
  assign w_o1_x     = {{LOG_WIN{w_old1[DS_W-1]}}, w_old1};
  assign w_o2_x     = {{LOG_WIN{w_old2[DS_W-1]}}, w_old2};
  assign w_sum_a_n  = r_sum_a + w_v_x - w_o1_x;
  assign w_sum_b_n  = r_sum_b + w_o1_x - w_o2_x;
  assign w_metric_n = {w_sum_a_n[WS_W-1], w_sum_a_n} - {w_sum_b_n[WS_W-1], w_sum_b_n};
  assign w_thr      = {1'b0, r_thr};
  assign w_cond     = (r_mode[0] && (w_metric_n >= w_thr)) ||
                      (r_mode[1] && (w_metric_n <= -w_thr));

  always_comb begin
    w_n_m1 = (downsample_num == '0) ? '0 : downsample_num - 1'b1;
    if (window_width == '0)
      w_w_lat = WIN_W'(1);
    else if (window_width > WIN_W'(WIN_MAX))
      w_w_lat = WIN_W'(WIN_MAX);
    else
      w_w_lat = window_width;
  end

  always_comb begin
    w_state_n = r_state;
    w_restart = 1'b0;
    w_eval    = 1'b0;
    w_mvld_n  = 1'b0;
    w_trig_n  = 1'b0;
    w_armed_n = r_armed;
    w_fill_n  = r_fill_cnt;
    w_ho_n    = r_ho_cnt;
    if (!enable) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_en_d) begin
            w_restart = 1'b1;
            w_state_n = ST_FILL;
            w_fill_n  = '0;
            w_ho_n    = '0;
            w_armed_n = 1'b1;
          end
        end
        ST_FILL: begin
          if (r_dsout_vld) begin
            if (r_fill_cnt + 1'b1 == w_w2)
              w_eval = 1'b1;
            else
              w_fill_n = r_fill_cnt + 1'b1;
          end
        end
        ST_RUN: w_eval = r_dsout_vld;
        ST_HOLD: begin
          if (r_dsout_vld) begin
            w_mvld_n = 1'b1;
            if (!w_cond)
              w_armed_n = 1'b1;
            if (r_ho_cnt + 16'd1 == r_holdoff) begin
              w_state_n = ST_RUN;
              w_ho_n    = '0;
            end else begin
              w_ho_n = r_ho_cnt + 16'd1;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
      if (w_eval) begin
        w_mvld_n = 1'b1;
        if (w_cond && r_armed) begin
          w_trig_n  = 1'b1;
          w_armed_n = 1'b0;
          w_ho_n    = '0;
          w_state_n = (r_holdoff == '0) ? ST_RUN : ST_HOLD;
        end else begin
          if (!w_cond)
            w_armed_n = 1'b1;
          w_state_n = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b1;
      r_fill_cnt <= '0;
      r_ho_cnt   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_armed    <= w_armed_n;
      r_fill_cnt <= w_fill_n;
      r_ho_cnt   <= w_ho_n;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_win_evt)
      r_buf[r_wr] <= r_dsout;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      // Reset as "previously enabled" so a run needs a fresh 0->1 on enable.
      r_en_d       <= 1'b1;
      r_n_m1       <= '0;
      r_w          <= WIN_W'(1);
      r_abs        <= 1'b0;
      r_thr        <= '0;
      r_mode       <= '0;
      r_holdoff    <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_dsout      <= '0;
      r_dsout_vld  <= 1'b0;
      r_bvld       <= '0;
      r_wr         <= '0;
      r_sum_a      <= '0;
      r_sum_b      <= '0;
      r_metric     <= '0;
      r_metric_vld <= 1'b0;
      r_trig       <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (w_restart) begin
        r_n_m1       <= w_n_m1;
        r_w          <= w_w_lat;
        r_abs        <= abs_mode;
        r_thr        <= threshold;
        r_mode       <= edge_mode;
        r_holdoff    <= holdoff;
        r_cnt        <= '0;
        r_acc        <= '0;
        r_dsout      <= '0;
        r_dsout_vld  <= 1'b0;
        r_bvld       <= '0;
        r_wr         <= '0;
        r_sum_a      <= '0;
        r_sum_b      <= '0;
        r_metric     <= '0;
        r_metric_vld <= 1'b0;
        r_trig       <= 1'b0;
      end else if (!enable) begin
        r_dsout      <= '0;
        r_dsout_vld  <= 1'b0;
        r_metric     <= '0;
        r_metric_vld <= 1'b0;
        r_trig       <= 1'b0;
      end else begin
        r_dsout_vld <= 1'b0;
        if (w_accept) begin
          if (w_ds_last) begin
            r_dsout     <= w_acc_sum;
            r_dsout_vld <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
          end else begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        r_metric_vld <= w_mvld_n;
        r_trig       <= w_trig_n;
        if (w_win_evt) begin
          r_bvld[r_wr] <= 1'b1;
          r_wr         <= r_wr + 1'b1;
          r_sum_a      <= w_sum_a_n;
          r_sum_b      <= w_sum_b_n;
          r_metric     <= w_metric_n;
        end
      end
    end
  end

  assign dsout      = r_dsout;
  assign dsout_vld  = r_dsout_vld;
  assign metric     = r_metric;
  assign metric_vld = r_metric_vld;
  assign trig       = r_trig;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_edge_sum_trigger.sv
// Testbench for edge_sum_trigger: stimulus pushes expected decimated values and
// metrics (with cycle stamps) into queues; a negedge monitor pops and compares.
module tb_edge_sum_trigger;
  localparam int DATA_W   = 10;
  localparam int DS_CNT_W = 8;
  localparam int WIN_MAX  = 32;
  localparam int DS_W     = DATA_W + DS_CNT_W;
  localparam int M_W      = DS_W + $clog2(WIN_MAX) + 1;

  logic                ap_clk = 1'b0;
  logic                ap_rst;
  logic                enable;
  logic [DATA_W-1:0]   datain;
  logic                datain_vld;
  logic                abs_mode;
  logic [DS_CNT_W-1:0] downsample_num;
  logic [5:0]          window_width;
  logic [M_W-2:0]      threshold;
  logic [1:0]          edge_mode;
  logic [15:0]         holdoff;
  logic [DS_W-1:0]     dsout;
  logic                dsout_vld;
  logic [M_W-1:0]      metric;
  logic                metric_vld;
  logic                trig;
  logic                busy;

  edge_sum_trigger #(.DATA_W(DATA_W), .DS_CNT_W(DS_CNT_W), .WIN_MAX(WIN_MAX)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .enable(enable), .datain(datain),
    .datain_vld(datain_vld), .abs_mode(abs_mode), .downsample_num(downsample_num),
    .window_width(window_width), .threshold(threshold), .edge_mode(edge_mode),
    .holdoff(holdoff), .dsout(dsout), .dsout_vld(dsout_vld), .metric(metric),
    .metric_vld(metric_vld), .trig(trig), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct { int cyc; longint val; } ds_exp_t;
  typedef struct { int cyc; longint val; bit trg; } m_exp_t;
  ds_exp_t ds_q[$];
  m_exp_t  m_q[$];
  ds_exp_t ds_e;
  m_exp_t  m_e;

  int n_checks = 0;
  int n_pass   = 0;
  int n_trig_seen = 0;

  task automatic check(string name, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic unexpected(string name);
    n_checks++;
    $display("FAIL %s: strobe high with no expected entry (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  int      m_n, m_w, m_thr, m_h;
  bit [1:0] m_mode;
  bit      m_abs, model_on = 1'b0;
  int      part, pc, supp;
  bit      armed;
  longint  dec[$];

  function automatic longint wsum(int lo, int hi);
    longint r = 0;
    for (int i = lo; i <= hi; i++)
      if (i >= 0) r += dec[i];
    return r;
  endfunction

  task automatic model_sample(int d, int cap);
    int s, k;
    longint m;
    bit cond, t;
    s = d - 512;
    if (m_abs && s < 0) s = -s;
    part += s;
    pc++;
    if (pc == m_n) begin
      dec.push_back(part);
      ds_q.push_back('{cap, part});
      part = 0;
      pc = 0;
      k = dec.size();
      if (k >= 2 * m_w) begin
        m = wsum(k - m_w, k - 1) - wsum(k - 2 * m_w, k - m_w - 1);
        cond = (m_mode[0] && m >= m_thr) || (m_mode[1] && m <= -m_thr);
        t = 1'b0;
        if (k > supp && cond && armed) begin
          t = 1'b1;
          armed = 1'b0;
          supp = k + m_h;
        end else if (!cond) begin
          armed = 1'b1;
        end
        m_q.push_back('{cap + 1, m, t});
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge ap_clk) begin
    if (dsout_vld) begin
      if (ds_q.size() == 0) unexpected("dsout_vld");
      else begin
        ds_e = ds_q.pop_front();
        check("dsout_cycle", cyc, ds_e.cyc);
        check("dsout", $signed(dsout), ds_e.val);
      end
    end
    if (metric_vld) begin
      if (m_q.size() == 0) unexpected("metric_vld");
      else begin
        m_e = m_q.pop_front();
        check("metric_cycle", cyc, m_e.cyc);
        check("metric", $signed(metric), m_e.val);
        check("trig", trig, m_e.trg);
      end
    end else if (trig) begin
      unexpected("trig_without_metric_vld");
    end
    if (trig) n_trig_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic send(bit v, int d);
    datain_vld = v;
    datain     = DATA_W'(d);
    if (v && enable && model_on) model_sample(d, cyc + 1);
    @(posedge ap_clk); #1;
    datain_vld = 1'b0;
  endtask

  task automatic start_run(int dn, int ww, int thr, int md, int hold, int ab);
    downsample_num = DS_CNT_W'(dn);
    window_width   = 6'(ww);
    threshold      = (M_W-1)'(thr);
    edge_mode      = 2'(md);
    holdoff        = 16'(hold);
    abs_mode       = 1'(ab);
    datain_vld     = 1'b0;
    m_n    = (dn == 0) ? 1 : dn;
    m_w    = (ww == 0) ? 1 : ((ww > WIN_MAX) ? WIN_MAX : ww);
    m_thr  = thr;
    m_mode = 2'(md);
    m_h    = hold;
    m_abs  = 1'(ab);
    part = 0; pc = 0; supp = 0; armed = 1'b1;
    dec.delete();
    model_on = 1'b1;
    enable = 1'b1;
    @(posedge ap_clk); #1;
    check("busy_run", busy, 1);
  endtask

  task automatic garble_cfg();
    downsample_num = DS_CNT_W'($urandom);
    window_width   = 6'($urandom_range(0, 63));
    threshold      = (M_W-1)'($urandom);
    edge_mode      = 2'($urandom);
    holdoff        = 16'($urandom);
    abs_mode       = 1'($urandom);
  endtask

  task automatic end_run();
    repeat (5) send(1'b0, 512);
    // Sample coinciding with enable falling must be discarded.
    enable     = 1'b0;
    datain_vld = 1'b1;
    datain     = DATA_W'($urandom);
    @(posedge ap_clk); #1;
    datain_vld = 1'b0;
    repeat (3) begin @(posedge ap_clk); #1; end
    check("busy_idle", busy, 0);
    check("ds_queue_drained", ds_q.size(), 0);
    check("metric_queue_drained", m_q.size(), 0);
    ds_q.delete();
    m_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lvl;
    ap_rst = 1'b1; enable = 1'b0; datain = '0; datain_vld = 1'b0;
    abs_mode = 1'b0; downsample_num = '0; window_width = '0; threshold = '0;
    edge_mode = '0; holdoff = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_dsout", dsout, 0);
    check("rst_dsout_vld", dsout_vld, 0);
    check("rst_metric", metric, 0);
    check("rst_metric_vld", metric_vld, 0);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    ap_rst = 1'b0;
    repeat (3) begin @(posedge ap_clk); #1; end

    // Rising step
    t0 = n_trig_seen;
    start_run(2, 3, 500, 1, 0, 0);
    repeat (40) send(1'b1, 512);
    repeat (20) send(1'b1, 612);
    end_run();
    check("step_rise_trig_count", n_trig_seen - t0, 1);

    // Falling step, falling mode then rising mode
    t0 = n_trig_seen;
    start_run(2, 3, 500, 2, 0, 0);
    repeat (40) send(1'b1, 612);
    repeat (20) send(1'b1, 512);
    end_run();
    check("step_fall_trig_count", n_trig_seen - t0, 1);
    t0 = n_trig_seen;
    start_run(2, 3, 500, 1, 0, 0);
    repeat (40) send(1'b1, 612);
    repeat (20) send(1'b1, 512);
    end_run();
    check("step_fall_rise_mode_trig_count", n_trig_seen - t0, 0);

    // Square wave, holdoff and re-arm
    start_run(2, 3, 500, 3, 20, 0);
    for (int h = 0; h < 10; h++)
      repeat (12) send(1'b1, (h % 2 == 0) ? 512 : 612);
    end_run();

    // Window clamps
    start_run(1, 0, 200, 3, 0, 0);
    repeat (30) send(1'b1, $urandom_range(400, 624));
    end_run();
    start_run(1, 40, 800, 3, 5, 0);
    repeat (90) send(1'b1, $urandom_range(300, 724));
    end_run();

    // Absolute mode with gaps
    t0 = n_trig_seen;
    start_run(4, 2, 10, 3, 0, 1);
    for (int i = 0; i < 80; i++) begin
      while ($urandom_range(0, 2) != 0) send(1'b0, 0);
      send(1'b1, (i % 2 == 0) ? 412 : 612);
    end
    end_run();
    check("abs_gap_trig_count", n_trig_seen - t0, 0);

    // Randomised runs; config inputs scrambled while enabled
    for (int r = 0; r < 5; r++) begin
      start_run($urandom_range(0, 5), $urandom_range(0, 40), $urandom_range(50, 2000),
                $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 1));
      garble_cfg();
      lvl = $urandom_range(0, 1023);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 11) == 0) lvl = $urandom_range(0, 1023);
        if (r != 0 && $urandom_range(0, 3) == 0) send(1'b0, 0);
        send(1'b1, lvl);
      end
      end_run();
    end

    // Reset during HOLDOFF
    t0 = n_trig_seen;
    start_run(1, 2, 300, 1, 100, 0);
    repeat (10) send(1'b1, 512);
    repeat (10) send(1'b1, 712);
    repeat (4) send(1'b0, 0);
    check("pre_reset_trig_count", n_trig_seen - t0, 1);
    check("pre_reset_busy", busy, 1);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("midrst_dsout", dsout, 0);
    check("midrst_dsout_vld", dsout_vld, 0);
    check("midrst_metric", metric, 0);
    check("midrst_metric_vld", metric_vld, 0);
    check("midrst_trig", trig, 0);
    check("midrst_busy", busy, 0);
    model_on = 1'b0;
    t0 = n_trig_seen;
    repeat (20) send(1'b1, $urandom_range(0, 1023));
    check("post_reset_busy", busy, 0);
    check("post_reset_trig_count", n_trig_seen - t0, 0);
    enable = 1'b0;
    repeat (2) begin @(posedge ap_clk); #1; end
    t0 = n_trig_seen;
    start_run(1, 2, 300, 1, 0, 0);
    repeat (10) send(1'b1, 512);
    repeat (10) send(1'b1, 712);
    end_run();
    check("rerun_trig_count", n_trig_seen - t0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
